// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-requester AddrData bus arbiter.
package mem_bus_pkg;

    localparam int unsigned BURST_LEN = 4;
    localparam int unsigned BUS_W     = 16;
    // Page field of the burst address; decoded by the memory controllers, not here.
    localparam int unsigned PAGE_MSB  = 15;
    localparam int unsigned PAGE_LSB  = 12;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StBeat,
        StRdTail,
        StTurn
    } arb_state_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; the last-granted pointer moves only when a grant is taken.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       resetH,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic       any_req,
    output logic       winner
);

    logic last_q;

    assign any_req = |req;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        winner = req[1];
        if (req == 2'b11) begin
            winner = ~last_q;
        end
    end

    always_ff @(posedge clk or posedge resetH) begin
        if (resetH) begin
            last_q <= 1'b1;
        end else if (grant_en && any_req) begin
            last_q <= winner;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester burst front end for the multiplexed AddrData bus: one address
// cycle followed by four data beats, with round-robin ownership.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned RD_DLY = 1
) (
    input  logic                       clk,
    input  logic                       resetH,
    input  logic [1:0]                 req,
    input  logic [1:0]                 req_rw,
    input  logic [1:0][BUS_W-1:0]      req_addr,
    input  logic [1:0][3:0][BUS_W-1:0] req_wdata,
    output logic [1:0]                 gnt,
    output logic [BUS_W-1:0]           rdata,
    output logic [1:0]                 rvalid,
    output logic [1:0]                 done,
    inout  tri   [BUS_W-1:0]           AddrData,
    output logic                       AddrValid,
    output logic                       rw
);

    localparam logic [1:0] LAST_BEAT  = 2'(BURST_LEN - 1);
    localparam logic [1:0] FIRST_BEAT = 2'(RD_DLY);
    localparam logic [1:0] TAIL_LAST  = 2'((RD_DLY == 0) ? 0 : RD_DLY - 1);

    arb_state_t       state_q, state_d;
    logic             owner_q, owner_d;
    logic             rw_q, rw_d;
    logic [BUS_W-1:0] addr_q, addr_d;
    logic [1:0]       beat_q, beat_d;
    logic [1:0]       tail_q, tail_d;
    logic [BUS_W-1:0] rdata_q;
    logic [1:0]       rvalid_q;

    logic             grant_en;
    logic             any_req;
    logic             winner;
    logic             sample;
    logic             bus_oe;
    logic [BUS_W-1:0] bus_out;

    rr_arbiter2 u_rr (
        .clk      (clk),
        .resetH   (resetH),
        .req      (req),
        .grant_en (grant_en),
        .any_req  (any_req),
        .winner   (winner)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        beat_d   = beat_q;
        tail_d   = tail_q;
        grant_en = 1'b0;
        unique case (state_q)
            StIdle, StTurn: begin
                state_d = StIdle;
                if (any_req) begin
                    grant_en = 1'b1;
                    owner_d  = winner;
                    rw_d     = req_rw[winner];
                    addr_d   = req_addr[winner];
                    state_d  = StAddr;
                end
            end
            StAddr: begin
                beat_d  = 2'd0;
                state_d = StBeat;
            end
            StBeat: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == LAST_BEAT) begin
                    if (rw_q && (RD_DLY > 0)) begin
                        tail_d  = 2'd0;
                        state_d = StRdTail;
                    end else begin
                        state_d = StTurn;
                    end
                end
            end
            StRdTail: begin
                tail_d = tail_q + 2'd1;
                if (tail_q == TAIL_LAST) begin
                    state_d = StTurn;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Read word k arrives RD_DLY cycles after beat slot k, so the capture window
    // slides from the late beats into the tail.
    assign sample = rw_q && (((state_q == StBeat) && (beat_q >= FIRST_BEAT)) ||
                             (state_q == StRdTail));

    always_ff @(posedge clk or posedge resetH) begin
        if (resetH) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            beat_q   <= 2'd0;
            tail_q   <= 2'd0;
            rdata_q  <= '0;
            rvalid_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            beat_q   <= beat_d;
            tail_q   <= tail_d;
            rvalid_q <= sample ? onehot2(owner_q) : 2'b00;
            if (sample) begin
                rdata_q <= AddrData;
            end
        end
    end

    // Outputs decode straight from state so an asynchronous reset drops the bus at once.
    always_comb begin
        gnt       = (state_q == StIdle) ? 2'b00 : onehot2(owner_q);
        done      = (state_q == StTurn) ? onehot2(owner_q) : 2'b00;
        AddrValid = (state_q == StAddr);
        rw        = (state_q == StAddr) && rw_q;
        bus_oe    = (state_q == StAddr) || ((state_q == StBeat) && !rw_q);
        bus_out   = (state_q == StAddr) ? addr_q : req_wdata[owner_q][beat_q];
    end

    assign AddrData = bus_oe ? bus_out : {BUS_W{1'bz}};
    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: default RD_DLY=1 instance plus an RD_DLY=0 instance.
module tb_mem_bus_arbiter;

    localparam int EV_ADDR = 0;
    localparam int EV_RV   = 1;
    localparam int EV_DONE = 2;

    typedef struct {
        int          kind;
        int          cyc;
        logic [1:0]  who;
        logic [15:0] data;
        logic        rwv;
    } exp_t;

    logic clk;
    logic resetH;
    int   cyc;
    int   total;
    int   bad;
    exp_t q0[$];
    exp_t q1[$];

    // RD_DLY=1 instance
    logic [1:0]            req, req_rw, gnt, rvalid, done;
    logic [1:0][15:0]      req_addr;
    logic [1:0][3:0][15:0] req_wdata;
    logic [15:0]           rdata, mem_drv;
    logic                  AddrValid, rw, mem_oe;
    tri1  [15:0]           AddrData;

    // RD_DLY=0 instance
    logic [1:0]            z_req, z_req_rw, z_gnt, z_rvalid, z_done;
    logic [1:0][15:0]      z_req_addr;
    logic [1:0][3:0][15:0] z_req_wdata;
    logic [15:0]           z_rdata, z_mem_drv;
    logic                  z_addrvalid, z_rw, z_mem_oe;
    tri1  [15:0]           z_bus;

    logic [15:0] wr_words [4];
    logic [15:0] rd_words [4];

    assign AddrData = mem_oe ? mem_drv : 16'bz;
    assign z_bus    = z_mem_oe ? z_mem_drv : 16'bz;

    mem_bus_arbiter #(.RD_DLY(1)) dut (
        .clk       (clk),
        .resetH    (resetH),
        .req       (req),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .done      (done),
        .AddrData  (AddrData),
        .AddrValid (AddrValid),
        .rw        (rw)
    );

    mem_bus_arbiter #(.RD_DLY(0)) dut0 (
        .clk       (clk),
        .resetH    (resetH),
        .req       (z_req),
        .req_rw    (z_req_rw),
        .req_addr  (z_req_addr),
        .req_wdata (z_req_wdata),
        .gnt       (z_gnt),
        .rdata     (z_rdata),
        .rvalid    (z_rvalid),
        .done      (z_done),
        .AddrData  (z_bus),
        .AddrValid (z_addrvalid),
        .rw        (z_rw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic void push(input int d, input int kind, input int c, input logic [1:0] who,
                                 input logic [15:0] data, input logic rwv);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        e.who  = who;
        e.data = data;
        e.rwv  = rwv;
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endfunction

    task automatic observe(input int d, input int kind, input logic [1:0] who,
                           input logic [15:0] data, input logic rwv);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (d == 0 && q0.size() > 0) begin
            e    = q0.pop_front();
            have = 1'b1;
        end else if (d == 1 && q1.size() > 0) begin
            e    = q1.pop_front();
            have = 1'b1;
        end
        if (!have) begin
            total++;
            bad++;
            $display("FAIL unexpected_event dut%0d: got kind %0d who %b at cycle %0d, want none",
                     d, kind, who, cyc);
        end else begin
            chk($sformatf("ev_kind_d%0d", d), kind, e.kind);
            chk($sformatf("ev_cycle_d%0d_k%0d", d, kind), cyc, e.cyc);
            chk($sformatf("ev_who_d%0d_k%0d", d, kind), {30'd0, who}, {30'd0, e.who});
            if (kind != EV_DONE) chk($sformatf("ev_data_d%0d_k%0d", d, kind), data, e.data);
            if (kind == EV_ADDR) chk($sformatf("ev_rw_d%0d", d), rwv, e.rwv);
        end
    endtask

    // Monitor: every presented output is matched against the next expected event.
    always @(negedge clk) begin
        if (!resetH) begin
            if (AddrValid)       observe(0, EV_ADDR, gnt, AddrData, rw);
            if (rvalid != 2'b00) observe(0, EV_RV, rvalid, rdata, 1'b0);
            if (done != 2'b00)   observe(0, EV_DONE, done, 16'h0, 1'b0);
            if (z_addrvalid)       observe(1, EV_ADDR, z_gnt, z_bus, z_rw);
            if (z_rvalid != 2'b00) observe(1, EV_RV, z_rvalid, z_rdata, 1'b0);
            if (z_done != 2'b00)   observe(1, EV_DONE, z_done, 16'h0, 1'b0);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int t0;
        total = 0;
        bad   = 0;
        wr_words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        rd_words = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
        resetH = 1'b1;
        req = 2'b00; req_rw = 2'b00; req_addr = '0; req_wdata = '0;
        z_req = 2'b00; z_req_rw = 2'b00; z_req_addr = '0; z_req_wdata = '0;
        mem_oe = 1'b0; mem_drv = '0; z_mem_oe = 1'b0; z_mem_drv = '0;

        // Reset values
        step(2);
        chk("rst_gnt", gnt, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_done", done, 0);
        chk("rst_addrvalid", AddrValid, 0);
        chk("rst_rw", rw, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_bus", AddrData, 16'hFFFF);
        resetH = 1'b0;
        step(2);

        // Single write from requester 0
        req[0] = 1'b1; req_rw[0] = 1'b0; req_addr[0] = 16'h2010;
        req_wdata[0] = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        t0 = cyc + 1;
        push(0, EV_ADDR, t0, 2'b01, 16'h2010, 1'b0);
        push(0, EV_DONE, t0 + 5, 2'b01, 16'h0, 1'b0);
        step(1);
        chk("wr_gnt_t0", gnt, 2'b01);
        req[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1);
            chk($sformatf("wr_beat%0d", k), AddrData, wr_words[k]);
        end
        step(1);
        chk("wr_t5_bus_released", AddrData, 16'hFFFF);
        chk("wr_t5_gnt", gnt, 2'b01);
        step(1);
        chk("wr_t6_idle_gnt", gnt, 2'b00);

        // Read from requester 1, memory answers one cycle after each slot
        req[1] = 1'b1; req_rw[1] = 1'b1; req_addr[1] = 16'h2040;
        t0 = cyc + 1;
        push(0, EV_ADDR, t0, 2'b10, 16'h2040, 1'b1);
        for (int k = 0; k < 4; k++) push(0, EV_RV, t0 + 3 + k, 2'b10, rd_words[k], 1'b0);
        push(0, EV_DONE, t0 + 6, 2'b10, 16'h0, 1'b0);
        step(1);
        chk("rd_gnt_t0", gnt, 2'b10);
        req[1] = 1'b0;
        step(1);
        chk("rd_t1_bus_released", AddrData, 16'hFFFF);
        for (int k = 0; k < 4; k++) begin
            step(1);
            mem_oe = 1'b1;
            mem_drv = rd_words[k];
            #1;
            chk($sformatf("rd_t%0d_bus_mem_only", k + 2), AddrData, rd_words[k]);
        end
        step(1);
        mem_oe = 1'b0;
        #1;
        chk("rd_t6_bus_released", AddrData, 16'hFFFF);
        step(1);
        chk("rd_t7_idle_gnt", gnt, 2'b00);

        // Tie straight after reset: 0 first, then 1 with no idle gap
        resetH = 1'b1;
        step(1);
        resetH = 1'b0;
        step(1);
        req = 2'b11; req_rw = 2'b00;
        req_addr[0] = 16'h1000; req_addr[1] = 16'h1100;
        req_wdata[1] = {16'h5004, 16'h5003, 16'h5002, 16'h5001};
        t0 = cyc + 1;
        push(0, EV_ADDR, t0, 2'b01, 16'h1000, 1'b0);
        push(0, EV_DONE, t0 + 5, 2'b01, 16'h0, 1'b0);
        push(0, EV_ADDR, t0 + 6, 2'b10, 16'h1100, 1'b0);
        push(0, EV_DONE, t0 + 11, 2'b10, 16'h0, 1'b0);
        step(1);
        req[0] = 1'b0;
        step(6);
        chk("tie_t6_gnt", gnt, 2'b10);
        req[1] = 1'b0;
        step(6);
        chk("tie_t12_idle_gnt", gnt, 2'b00);

        // Fairness: both held for four bursts
        req = 2'b11;
        req_addr[0] = 16'h3000; req_addr[1] = 16'h4000;
        t0 = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            push(0, EV_ADDR, t0 + 6 * i, (i % 2 == 0) ? 2'b01 : 2'b10,
                 (i % 2 == 0) ? 16'h3000 : 16'h4000, 1'b0);
            push(0, EV_DONE, t0 + 6 * i + 5, (i % 2 == 0) ? 2'b01 : 2'b10, 16'h0, 1'b0);
        end
        step(19);
        chk("fair_4th_gnt", gnt, 2'b10);
        req = 2'b00;
        step(6);
        chk("fair_idle_gnt", gnt, 2'b00);

        // Reset in T2 of a write
        req[0] = 1'b1; req_addr[0] = 16'h6000;
        t0 = cyc + 1;
        push(0, EV_ADDR, t0, 2'b01, 16'h6000, 1'b0);
        step(1);
        req[0] = 1'b0;
        step(2);
        chk("mid_t2_word", AddrData, 16'h2222);
        resetH = 1'b1;
        #1;
        chk("mid_rst_bus", AddrData, 16'hFFFF);
        chk("mid_rst_addrvalid", AddrValid, 0);
        chk("mid_rst_gnt", gnt, 2'b00);
        chk("mid_rst_done", done, 2'b00);
        #1;
        resetH = 1'b0;
        step(7);
        chk("mid_after_gnt", gnt, 2'b00);
        req[0] = 1'b1; req_addr[0] = 16'h7000;
        t0 = cyc + 1;
        push(0, EV_ADDR, t0, 2'b01, 16'h7000, 1'b0);
        push(0, EV_DONE, t0 + 5, 2'b01, 16'h0, 1'b0);
        step(1);
        chk("mid_restart_gnt", gnt, 2'b01);
        req[0] = 1'b0;
        step(6);
        chk("mid_restart_idle", gnt, 2'b00);

        // RD_DLY=0 read on the second instance
        z_req[0] = 1'b1; z_req_rw[0] = 1'b1; z_req_addr[0] = 16'h5000;
        t0 = cyc + 1;
        push(1, EV_ADDR, t0, 2'b01, 16'h5000, 1'b1);
        for (int k = 0; k < 4; k++) push(1, EV_RV, t0 + 2 + k, 2'b01, rd_words[k], 1'b0);
        push(1, EV_DONE, t0 + 5, 2'b01, 16'h0, 1'b0);
        step(1);
        z_req[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1);
            z_mem_oe = 1'b1;
            z_mem_drv = rd_words[k];
        end
        step(1);
        z_mem_oe = 1'b0;
        #1;
        chk("z_t5_bus_released", z_bus, 16'hFFFF);
        step(1);
        chk("z_t6_idle_gnt", z_gnt, 2'b00);

        step(3);
        chk("scoreboard0_drained", q0.size(), 0);
        chk("scoreboard1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
